// File: rtl/paint_scheduler_if.sv
// Handshake/bus bundle between the paint scheduler, its painter pipeline and the framebuffer sink.
// The master side is the scheduler; the slave side is the painter/sink environment.
interface paint_scheduler_if #(
  parameter int FRAME_BITS = 16
);
  logic                  go;
  logic                  stall;
  logic [FRAME_BITS-1:0] frame;
  logic [5:0]            x;
  logic [5:0]            y;
  logic [23:0]           rgb24;
  logic                  wr_en;
  logic [12:0]           wr_addr;
  logic [23:0]           wr_data;
  logic                  buf_sel;
  logic                  busy;
  logic                  frame_done;

  modport master (
    input  go, stall, rgb24,
    output frame, x, y, wr_en, wr_addr, wr_data, buf_sel, busy, frame_done
  );

  modport slave (
    output go, stall, rgb24,
    input  frame, x, y, wr_en, wr_addr, wr_data, buf_sel, busy, frame_done
  );
endinterface

// File: rtl/paint_scheduler.sv
// Raster scheduler for a 64x64 double-buffered framebuffer: issues pixel coordinates to a
// fixed-latency painter and writes its results into the back buffer, then flips buffers.
module paint_scheduler #(
  parameter int FRAME_BITS = 16,
  parameter int LATENCY    = 3
) (
  input logic               clk,
  input logic               resetn,
  paint_scheduler_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [5:0]            r_x;
  logic [5:0]            r_y;
  logic [FRAME_BITS-1:0] r_frame;
  logic                  r_buf_sel;
  logic                  r_frame_done;
  logic [LATENCY-1:0]    r_vld;
  logic [12:0]           r_addr [LATENCY];
  logic                  w_issue;
  logic                  w_last_write;
  logic                  w_frame_end;

  // The last pixel of a frame is the only one whose {y, x} is all ones.
  assign w_last_write = r_vld[LATENCY-1] && (r_addr[LATENCY-1][11:0] == 12'hFFF);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_frame_end = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.go) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        w_issue = !bus.stall;
        if (w_issue && (r_x == 6'd63) && (r_y == 6'd63)) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_last_write) begin
          w_state_nxt = IDLE;
          w_frame_end = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // The 12-bit {y, x} raster counter wraps to 0 after (63,63), leaving x = y = 0 for DRAIN/IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_issue) begin
      {r_y, r_x} <= {r_y, r_x} + 12'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_frame      <= '0;
      r_buf_sel    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      if (w_frame_end) begin
        r_frame   <= r_frame + FRAME_BITS'(1);
        r_buf_sel <= ~r_buf_sel;
      end
    end
  end

  // Delay line matching the painter: advances every cycle, stalls only insert bubbles.
  // NOTE: the address stages are reset along with the valids so reset leaves no stale write state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vld <= '0;
      for (int k = 0; k < LATENCY; k++) r_addr[k] <= '0;
    end else begin
      r_vld[0]  <= w_issue;
      r_addr[0] <= {r_buf_sel, r_y, r_x};
      for (int k = 1; k < LATENCY; k++) begin
        r_vld[k]  <= r_vld[k-1];
        r_addr[k] <= r_addr[k-1];
      end
    end
  end

  assign bus.frame      = r_frame;
  assign bus.x          = r_x;
  assign bus.y          = r_y;
  assign bus.wr_en      = r_vld[LATENCY-1];
  assign bus.wr_addr    = r_addr[LATENCY-1];
  assign bus.wr_data    = bus.rgb24;
  assign bus.buf_sel    = r_buf_sel;
  assign bus.busy       = (r_state != IDLE);
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_paint_scheduler.sv
// Bench for paint_scheduler: whole frames driven from a table of scenarios, plus hand-written
// mid-frame reset and frame-counter wrap sequences.
module tb_paint_scheduler;

  localparam int LAT = 3;

  typedef struct {
    bit          stall_at_10;  // stall 5 cycles right after (10,0) is issued
    bit          noise;        // toggle go during ISSUE/DRAIN and stall during DRAIN
    int          exp_first_wr; // cycle of first write, cycle 0 = cycle in which go is sampled
    int          exp_done;     // cycle of frame_done pulse
    logic [12:0] exp_base;     // address of first write
    logic [15:0] exp_frame;    // frame after frame_done
    logic        exp_buf;      // buf_sel after frame_done
  } vec_t;

  logic clk = 1'b0;
  logic resetn;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs[5];

  paint_scheduler_if #(.FRAME_BITS(16)) bus ();
  paint_scheduler_if #(.FRAME_BITS(2))  bus2 ();

  paint_scheduler #(.FRAME_BITS(16), .LATENCY(LAT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.master)
  );

  paint_scheduler #(.FRAME_BITS(2), .LATENCY(LAT)) dut_wrap (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus2.master)
  );

  always #5 clk = ~clk;

  // Painter stand-in: a fresh colour every cycle, which wr_data must follow.
  initial begin
    bus.rgb24 = '0;
    forever begin
      @(posedge clk);
      #1 bus.rgb24 = 24'($urandom);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts at a negedge with the DUT in IDLE; returns at the negedge of the frame_done cycle.
  task automatic run_frame(input int idx, input vec_t v);
    int          t, first_wr, done_t, nwr, order_err, data_err, const_err, w10, w11, stall_left;
    bit          done, drain, stalled;
    logic [15:0] f0;
    logic        b0;
    t = 0; first_wr = -1; done_t = -1; nwr = 0; order_err = 0; data_err = 0; const_err = 0;
    w10 = -100; w11 = -100; stall_left = 0; done = 0; drain = 0; stalled = 0;
    bus.go    = 1'b1;
    bus.stall = 1'b0;
    f0 = bus.frame;
    b0 = bus.buf_sel;
    check($sformatf("v%0d_idle_busy", idx), bus.busy, 0);
    while (!done && t < 4300) begin
      @(negedge clk);
      t++;
      if (t == 1) begin
        check($sformatf("v%0d_busy_start", idx), bus.busy, 1);
        check($sformatf("v%0d_done_pulse_width", idx), bus.frame_done, 0);
      end
      if (bus.frame_done) begin
        done   = 1;
        done_t = t;
      end else begin
        if (bus.frame !== f0 || bus.buf_sel !== b0) const_err++;
        if (bus.wr_en) begin
          if (first_wr < 0) first_wr = t;
          if (bus.wr_addr !== v.exp_base + 13'(nwr)) order_err++;
          if (bus.wr_data !== bus.rgb24) data_err++;
          if (bus.wr_addr[11:0] == 12'd10) w10 = t;
          if (bus.wr_addr[11:0] == 12'd11) w11 = t;
          nwr++;
        end
        if (v.stall_at_10) begin
          if (!stalled && bus.busy && bus.x == 6'd11 && bus.y == 6'd0) begin
            stalled    = 1;
            bus.stall  = 1'b1;
            stall_left = 5;
          end else if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) begin
              check($sformatf("v%0d_x_held_in_stall", idx), bus.x, 11);
              bus.stall = 1'b0;
            end
          end
        end
        if (v.noise) begin
          bus.go = t[0];
          if (drain) bus.stall = t[1];
          if (bus.x == 6'd63 && bus.y == 6'd63) drain = 1;
        end
      end
    end
    bus.stall = 1'b0;
    check($sformatf("v%0d_first_write_cycle", idx), first_wr, v.exp_first_wr);
    check($sformatf("v%0d_frame_done_cycle", idx), done_t, v.exp_done);
    check($sformatf("v%0d_write_count", idx), nwr, 4096);
    check($sformatf("v%0d_addr_order_errors", idx), order_err, 0);
    check($sformatf("v%0d_wr_data_errors", idx), data_err, 0);
    check($sformatf("v%0d_frame_bufsel_changes", idx), const_err, 0);
    check($sformatf("v%0d_frame_after", idx), bus.frame, v.exp_frame);
    check($sformatf("v%0d_buf_sel_after", idx), bus.buf_sel, v.exp_buf);
    if (v.stall_at_10) check($sformatf("v%0d_bubble_gap", idx), w11 - w10, 6);
  endtask

  initial begin
    int cnt, spurious;
    vecs[0] = '{0, 0, 1 + LAT, 1 + 4096 + LAT,     13'h0000, 16'd1, 1'b1};
    vecs[1] = '{0, 0, 1 + LAT, 1 + 4096 + LAT,     13'h1000, 16'd2, 1'b0};
    vecs[2] = '{1, 0, 1 + LAT, 1 + 4096 + LAT + 5, 13'h0000, 16'd3, 1'b1};
    vecs[3] = '{0, 1, 1 + LAT, 1 + 4096 + LAT,     13'h1000, 16'd4, 1'b0};
    vecs[4] = '{0, 0, 1 + LAT, 1 + 4096 + LAT,     13'h0000, 16'd1, 1'b1};

    resetn     = 1'b0;
    bus.go     = 1'b0;
    bus.stall  = 1'b0;
    bus2.go    = 1'b0;
    bus2.stall = 1'b0;
    bus2.rgb24 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_xy", {bus.y, bus.x}, 0);
    check("rst_frame_buf", {bus.frame, bus.buf_sel}, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Frames 0..3 run back to back: go stays high through each frame_done cycle.
    for (int i = 0; i < 4; i++) run_frame(i, vecs[i]);

    // Mid-frame reset while painting row 20.
    bus.go    = 1'b1;
    bus.stall = 1'b0;
    cnt = 0;
    while (!(bus.y == 6'd20 && bus.x == 6'd5) && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    check("reach_row20", {bus.y, bus.x}, {6'd20, 6'd5});
    resetn = 1'b0;
    bus.go = 1'b0;
    #1;
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_wr_en", bus.wr_en, 0);
    check("async_rst_frame_done", bus.frame_done, 0);
    check("async_rst_xy", {bus.y, bus.x}, 0);
    check("async_rst_frame_buf", {bus.frame, bus.buf_sel}, 0);
    spurious = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.wr_en || bus.busy) spurious++;
    end
    resetn = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.wr_en || bus.busy) spurious++;
    end
    check("no_activity_after_reset", spurious, 0);
    run_frame(4, vecs[4]);
    bus.go = 1'b0;

    // Frame counter wrap on the 2-bit instance: 1, 2, 3, then back to 0.
    bus2.go = 1'b1;
    for (int f = 0; f < 4; f++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!bus2.frame_done && cnt < 4300);
      check($sformatf("wrap_done_seen_%0d", f), bus2.frame_done, 1);
      check($sformatf("wrap_frame_%0d", f), bus2.frame, (f + 1) & 3);
      check($sformatf("wrap_buf_sel_%0d", f), bus2.buf_sel, (f + 1) & 1);
    end
    bus2.go = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/paint_scheduler.md
PAINT_SCHEDULER -- requirements
Module: paint_scheduler

Interface
REQ-001 Parameter: FRAME_BITS, default 16, width of the frame counter driven to the painter.
REQ-002 Parameter: LATENCY, default 3, painter pipeline depth in clocks from x/y/frame presented to rgb24 valid.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 go  input  1  start request, level, sampled only in IDLE.
REQ-006 stall  input  1  sink back-pressure; suspends issue of new pixels.
REQ-007 frame  output  FRAME_BITS  frame number presented to the painter.
REQ-008 x  output  6  painter column coordinate.
REQ-009 y  output  6  painter row coordinate.
REQ-010 rgb24  input  24  painter result, {blue, green, red}.
REQ-011 wr_en  output  1  framebuffer write strobe.
REQ-012 wr_addr  output  13  write address {buf_sel, y, x} of the pixel being written.
REQ-013 wr_data  output  24  equal to rgb24 in every cycle wr_en is high.
REQ-014 buf_sel  output  1  back buffer currently being painted; front buffer is ~buf_sel.
REQ-015 busy  output  1  high in ISSUE and DRAIN.
REQ-016 frame_done  output  1  one-cycle pulse when a full frame has been written.

Function
REQ-017 The block SHALL implement states IDLE, ISSUE, DRAIN.
REQ-018 IDLE: go=1 at an edge -> ISSUE next cycle with x=0, y=0; go=0 -> remain IDLE.
REQ-019 ISSUE: each cycle with stall=0 is an issue cycle; the current (x,y) is issued, then x increments; x wraps 63->0 with y incrementing (raster, x fastest).
REQ-020 ISSUE with stall=1: x, y held, no pixel issued (bubble); in-flight pixels still complete.
REQ-021 Issue of (63,63) -> DRAIN next cycle; x and y then hold 0.
REQ-022 A pixel issued in cycle n SHALL produce wr_en=1 in cycle n+LATENCY, with wr_addr carrying that pixel's coordinates and the buf_sel of its frame; bubbles produce wr_en=0.
REQ-023 Delayed valid and coordinates SHALL be held in a LATENCY-deep shift register that advances every cycle regardless of stall.
REQ-024 DRAIN: remain until the write for (63,63) occurs; in the following cycle frame_done=1, state=IDLE, frame incremented by 1, buf_sel inverted.
REQ-025 frame SHALL wrap from 2^FRAME_BITS-1 to 0.
REQ-026 frame and buf_sel SHALL be constant from the first issue to the last write of a frame.
REQ-027 stall in DRAIN or IDLE SHALL have no effect.
REQ-028 go=1 during the frame_done cycle SHALL start the next frame in the following cycle (back-to-back, no gap beyond one IDLE cycle).
REQ-029 go SHALL be ignored in ISSUE and DRAIN.
REQ-030 Unstalled frame: 4096 issue cycles; frame_done 4096+LATENCY cycles after the first issue cycle.

Reset
REQ-031 resetn=0 SHALL asynchronously force: state IDLE, frame=0, x=0, y=0, buf_sel=0, busy=0, wr_en=0, frame_done=0, shift register valids cleared.
REQ-032 Reset mid-frame SHALL discard all in-flight pixels; no wr_en until a new go after release.
REQ-033 After release, the first edge with go=1 SHALL behave per REQ-018.

Verification
REQ-034 Reset, go=1 held, stall=0 -> busy from cycle 1; first wr_en at cycle 1+LATENCY with wr_addr=0x0000; last wr_en wr_addr=0x0FFF; frame_done one cycle later; frame=1, buf_sel=1.
REQ-035 Second frame back-to-back -> addresses 0x1000..0x1FFF, frame_done, frame=2, buf_sel=0; exactly 4096 writes per frame, no duplicates.
REQ-036 stall=1 for 5 cycles after issue of (10,0) -> x holds at 11, 5 bubbles in wr_en exactly LATENCY cycles later, frame_done delayed by exactly 5 cycles.
REQ-037 Preload frame to 0xFFFF (run 65535 frames or force) -> after next frame_done frame=0x0000.
REQ-038 resetn pulsed low while y=20 -> outputs immediately reset values, no further wr_en, go=1 after release restarts at (0,0) with frame=0.
REQ-039 go toggled high during ISSUE/DRAIN and stall toggled during DRAIN -> no change in write sequence or frame_done timing.
